// File: rtl/acc_req_queue.sv
// Per-core accumulate request buffer: one circular FIFO per accumulator, each head
// offered to the accumulator arbiter as an independent valid/ready request.
module acc_req_queue #(
  parameter int N_ACC = 3,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(N_ACC)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   push_valid,
  input  logic [AW-1:0]                          push_acc,
  input  logic [31:0]                            push_data,
  output logic                                   push_ready,
  output logic [N_ACC-1:0]                       req_valid,
  input  logic [N_ACC-1:0]                       req_ready,
  output logic [N_ACC*32-1:0]                    req_data,
  output logic [N_ACC*($clog2(DEPTH)+1)-1:0]     count,
  output logic                                   all_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] wptr_q [N_ACC];
  logic [CW-1:0] wptr_d [N_ACC];
  logic [CW-1:0] rptr_q [N_ACC];
  logic [CW-1:0] rptr_d [N_ACC];
  logic [31:0]   mem_q  [N_ACC][DEPTH];

  logic [N_ACC-1:0] full;
  logic [N_ACC-1:0] empty;
  logic [N_ACC-1:0] push_sel;
  logic [N_ACC-1:0] pop;

  // Status and handshakes depend only on registered pointers, push_acc and
  // req_ready of the same FIFO; push_ready never sees req_ready.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    push_ready = 1'b0;
    full       = '0;
    empty      = '0;
    push_sel   = '0;
    pop        = '0;
    for (int i = 0; i < N_ACC; i++) begin
      empty[i] = (wptr_q[i] == rptr_q[i]);
      full[i]  = (wptr_q[i][PW-1:0] == rptr_q[i][PW-1:0]) &&
                 (wptr_q[i][PW] != rptr_q[i][PW]);
      // An out-of-range index matches no FIFO, so push_ready stays low for it.
      if (push_acc == AW'(i) && !full[i]) push_ready = 1'b1;
      push_sel[i] = push_valid && (push_acc == AW'(i)) && !full[i];
      pop[i]      = !empty[i] && req_ready[i];
      wptr_d[i]   = wptr_q[i] + CW'(push_sel[i]);
      rptr_d[i]   = rptr_q[i] + CW'(pop[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ACC; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ACC; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // NOTE: storage is not reset; equal pointers after reset make every stale entry invisible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ACC; i++) begin
      if (push_sel[i] && !reset) mem_q[i][wptr_q[i][PW-1:0]] <= push_data;
    end
  end

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    count     = '0;
    for (int i = 0; i < N_ACC; i++) begin
      req_valid[i]          = !empty[i];
      req_data[i*32 +: 32]  = mem_q[i][rptr_q[i][PW-1:0]];
      count[i*CW +: CW]     = wptr_q[i] - rptr_q[i];
    end
    all_empty = &empty;
  end

endmodule

// File: tb/tb_acc_req_queue.sv
// Self-checking bench for acc_req_queue: directed scenarios plus random traffic,
// scored against per-accumulator reference queues.
module tb_acc_req_queue;

  localparam int N_ACC = 3;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   push_valid;
  logic [AW-1:0]          push_acc;
  logic [31:0]            push_data;
  logic                   push_ready;
  logic [N_ACC-1:0]       req_valid;
  logic [N_ACC-1:0]       req_ready;
  logic [N_ACC*32-1:0]    req_data;
  logic [N_ACC*CW-1:0]    count;
  logic                   all_empty;

  acc_req_queue #(.N_ACC(N_ACC), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_acc   (push_acc),
    .push_data  (push_data),
    .push_ready (push_ready),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .count      (count),
    .all_empty  (all_empty)
  );

  always #5 clk = ~clk;

  // Reference model: contents of each accumulator queue as seen after the last edge,
  // plus the push (if any) the driver expects to land at the coming edge.
  logic [31:0] exp_q [N_ACC][$];
  int          pend_acc  = -1;
  logic        exp_ready = 1'b0;
  logic        mon_en    = 1'b0;
  int          n_checks  = 0;
  int          n_err     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares outputs mid-cycle, then retires heads that leave at the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int   sz [N_ACC];
      logic exp_all;
      exp_all = 1'b1;
      for (int i = 0; i < N_ACC; i++) begin
        sz[i] = exp_q[i].size() - ((pend_acc == i) ? 1 : 0);
        check($sformatf("req_valid[%0d]", i), 32'(req_valid[i]), 32'(sz[i] > 0));
        check($sformatf("count[%0d]", i), 32'(count[i*CW +: CW]), 32'(sz[i]));
        if (sz[i] > 0) check($sformatf("req_data[%0d]", i), req_data[i*32 +: 32], exp_q[i][0]);
        if (sz[i] > 0) exp_all = 1'b0;
      end
      check("all_empty", 32'(all_empty), 32'(exp_all));
      check("push_ready", 32'(push_ready), 32'(exp_ready));
      if (!reset) begin
        for (int i = 0; i < N_ACC; i++) begin
          if (sz[i] > 0 && req_ready[i]) void'(exp_q[i].pop_front());
        end
      end
    end
  end

  // Drive one cycle of stimulus (called just after a rising edge) and predict its effect.
  task automatic drive(input logic v, input int a, input logic [31:0] d,
                       input logic [N_ACC-1:0] rdy, input logic rst);
    reset      = rst;
    push_valid = v;
    push_acc   = AW'(a);
    push_data  = d;
    req_ready  = rdy;
    exp_ready  = (a < N_ACC) ? (exp_q[a].size() < DEPTH) : 1'b0;
    pend_acc   = -1;
    if (v && exp_ready && !rst) begin
      exp_q[a].push_back(d);
      pend_acc = a;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < N_ACC; i++) exp_q[i].delete();
    end
  endtask

  task automatic idle(input int n, input logic [N_ACC-1:0] rdy);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; push_valid = 1'b0; push_acc = '0; push_data = '0; req_ready = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b0, 0, 32'h0, 3'b000, 1'b1);

    // Single push to acc 1, popped on the following edge.
    drive(1'b1, 1, 32'h3F80_0000, 3'b000, 1'b0);
    drive(1'b0, 0, 32'h0, 3'b010, 1'b0);
    idle(1, 3'b000);

    // Fill acc 0, reject a fifth push, drain in order.
    for (int k = 1; k <= 4; k++) drive(1'b1, 0, 32'(k), 3'b000, 1'b0);
    drive(1'b1, 0, 32'h5, 3'b000, 1'b0);
    idle(5, 3'b001);

    // Full FIFO with simultaneous push and pop: only the pop, push lands next cycle.
    for (int k = 1; k <= 4; k++) drive(1'b1, 0, 32'h20 + 32'(k), 3'b000, 1'b0);
    drive(1'b1, 0, 32'h25, 3'b001, 1'b0);
    drive(1'b1, 0, 32'h25, 3'b000, 1'b0);
    idle(5, 3'b001);

    // Interleaved pushes to acc 0 and 2, then both heads pop together.
    drive(1'b1, 0, 32'hA, 3'b000, 1'b0);
    drive(1'b1, 2, 32'hB, 3'b000, 1'b0);
    drive(1'b1, 0, 32'hC, 3'b000, 1'b0);
    drive(1'b1, 2, 32'hD, 3'b000, 1'b0);
    idle(3, 3'b101);

    // Head of acc 2 held stable while not taken.
    drive(1'b1, 2, 32'h77, 3'b000, 1'b0);
    idle(5, 3'b000);
    idle(1, 3'b100);

    // Reset mid-operation with a push and a pop in the reset cycle.
    for (int k = 0; k < 3; k++) drive(1'b1, 1, 32'h10 + 32'(k), 3'b000, 1'b0);
    drive(1'b1, 1, 32'h99, 3'b010, 1'b1);
    idle(3, 3'b111);

    // Wrap-around on acc 2: continuous push and pop.
    for (int k = 0; k < 3*DEPTH; k++) drive(1'b1, 2, 32'h100 + 32'(k), 3'b100, 1'b0);
    idle(2, 3'b100);

    // Out-of-range index with entries buffered: nothing may change.
    drive(1'b1, 0, 32'h55, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 3, 32'hDEAD, 3'b000, 1'b0);
    idle(2, 3'b111);

    // Randomized traffic, including out-of-range pushes and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      int a;
      a = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, N_ACC-1));
      drive(1'($urandom_range(0, 3) != 0), a, $urandom(),
            N_ACC'($urandom_range(0, 7)), 1'($urandom_range(0, 299) == 0));
    end
    idle(DEPTH + 2, 3'b111);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_req_queue.md
# acc_req_queue

Per-core buffer between a core's issue stage and the shared floating-point accumulator registers in the parent FPR register file. The core pushes (accumulator index, 32-bit addend) pairs at up to one per cycle. The block holds them in one FIFO per accumulator and presents each FIFO head as an independent valid/ready request to the accumulator arbiter. It also reports when all queues are empty, which the join logic needs before reading accumulator values.

## Interface
- N_ACC, 3, number of accumulator registers; one FIFO and one request channel each.
- DEPTH, 4, entries per FIFO; must be a power of two, at least 2.
- AW, $clog2(N_ACC), width of the accumulator index.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- push_valid  in  1  core offers an accumulate request this cycle.
- push_acc  in  AW  target accumulator index.
- push_data  in  32  IEEE-754 single addend.
- push_ready  out  1  request accepted this cycle if push_valid is also high.
- req_valid[N_ACC]  out  1 each  FIFO i has a head entry.
- req_ready[N_ACC]  in  1 each  arbiter takes head of FIFO i this cycle.
- req_data[N_ACC]  out  32 each  head addend of FIFO i.
- count[N_ACC]  out  $clog2(DEPTH)+1 each  occupancy of FIFO i.
- all_empty  out  1  every FIFO holds 0 entries.

## Operation
- Storage: N_ACC circular buffers, each with DEPTH×32 data, a read pointer and a write pointer of $clog2(DEPTH)+1 bits (wrap bit included).
  - full: pointers equal except the MSB.
  - empty: pointers fully equal.
- Push:
  - push_ready = (push_acc < N_ACC) && !full[push_acc]. It is combinational on push_acc and on registered state only, never on req_ready.
  - On push_valid && push_ready, write push_data at wptr[push_acc] and increment that pointer.
  - An out-of-range push_acc leaves push_ready low forever. The core must not present it; the bench checks that no state changes.
- Pop: on req_valid[i] && req_ready[i], increment rptr[i]. Each FIFO pops independently, so up to N_ACC pops happen per cycle.
- Request outputs:
  - req_valid[i] = !empty[i].
  - req_data[i] = mem[i][rptr[i]].
  - While req_valid[i] is high and req_ready[i] is low, req_data[i] stays stable.
  - When req_valid[i] is low, req_data[i] is don't-care.
- Ordering: entries to the same accumulator leave in push order. There is no ordering across accumulators.
- count[i] = wptr[i] − rptr[i], modulo 2^($clog2(DEPTH)+1).
- all_empty = AND of empty[i]. It is registered-state derived, not combinational on inputs.
- Simultaneous push and pop on the same FIFO:
  - Non-full: both happen and count is unchanged.
  - Full: push_ready is low, so the pop happens alone. There is no full-bypass.
  - Empty: the push is accepted and the pop cannot occur because req_valid is low. There is no fall-through.

## Timing
- Reset values: all pointers 0; req_valid all 0; count all 0; all_empty 1. push_ready is 1 for any in-range push_acc.
- Reset mid-operation discards all buffered entries in the same edge. Pushes and pops presented in the reset cycle are ignored.
- Push-to-request latency: 1 cycle. An entry pushed at edge n is visible on req_valid/req_data after edge n, and is poppable at edge n+1 at the earliest.
- Pop-to-next-head: the next entry appears immediately after the popping edge, so back-to-back pops run at one per cycle.
- Full recovery: a pop at edge n raises push_ready for that index after edge n.
- No combinational path from req_ready to push_ready or to any req_valid.

## Test plan
- Reset, then push (acc 1, 0x3F800000) at cycle 0:
  - After edge 0: req_valid = 3'b010, req_data[1] = 0x3F800000, count[1] = 1, all_empty = 0.
  - With req_ready[1] high at edge 1: after edge 1, req_valid = 0 and all_empty = 1.
- Fill acc 0 with 0x1, 0x2, 0x3, 0x4 with req_ready low:
  - push_ready drops after the 4th push; a 5th push of 0x5 is not accepted and count[0] stays 4.
  - Raise req_ready[0]: heads appear in order 0x1, 0x2, 0x3, 0x4, one per cycle.
- Full FIFO with a push and a pop in the same cycle: only the pop happens, count goes 4→3, and the push is accepted the next cycle.
- Interleaved pushes to acc 0, 2, 0, 2 (data 0xA, 0xB, 0xC, 0xD), then req_ready = 3'b101 held:
  - Both heads pop every cycle: acc 0 yields 0xA, 0xC; acc 2 yields 0xB, 0xD.
  - all_empty rises after the second pop.
- Hold req_valid[2] with req_ready[2] low for 5 cycles: req_data[2] stays constant and count[2] is unchanged.
- Fill acc 1 with 3 entries, then assert reset together with a push and a pop:
  - After the edge: every count = 0 and all_empty = 1.
  - The pushed value never appears on req_data.
- Wrap-around: push and pop acc 2 continuously for 3×DEPTH cycles with incrementing data. No entry is lost or duplicated and count stays ≤ 1.
